// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared definitions for the sequential arithmetic blocks:
//               FSM state encodings and a compile-time ceil(log2) helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_RUN    = ST_RUN,
        S_FINISH = ST_FINISH
    } state_t;

    // Bits needed to hold values 0 .. value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq_if
// Description : START/BUSY/DONE handshake and operand/result bundle for the
//               sequential divider. master = controlling logic, slave = divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface divider_seq_if #(
    parameter int WIDTH = 8
);
    import arith_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div0;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div0
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div0
    );

endinterface
`default_nettype wire

// File: rtl/addsub_step.sv
`default_nettype none
// ============================================================================
// Module      : addsub_step
// Description : N-bit ripple adder/subtractor. mode=0 gives a+b, mode=1 gives
//               a-b as a + ~b + 1. co is the carry out (1 = no borrow when
//               subtracting).
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_step #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N-1:0] w_b;

    assign w_b = b ^ {N{mode}};

    // Ripple carry chain; the carry is a procedural local so the chain is a
    // single combinational process rather than a self-referencing vector.
    always_comb begin
        logic w_carry;
        s       = '0;
        w_carry = mode;
        for (int i = 0; i < N; i++) begin
            s[i]    = a[i] ^ w_b[i] ^ w_carry;
            w_carry = (a[i] & w_b[i]) | (w_carry & (a[i] ^ w_b[i]));
        end
        co = w_carry;
    end

endmodule
`default_nettype wire

// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq
// Description : Sequential restoring unsigned divider, WIDTH/WIDTH bits.
//               One quotient bit per clock via a trial subtraction of the
//               divisor from the shifted partial remainder. Results and DONE
//               appear WIDTH+1 edges after an accepted START.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    divider_seq_if.slave  bus
);

    localparam int CW = clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_q;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_d;          // latched divisor
    logic [WIDTH:0]   r_p;          // partial remainder
    logic [CW-1:0]    r_cnt;        // remaining RUN steps

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div0;
    logic             r_done;

    logic [WIDTH:0]   w_pshift;
    logic [WIDTH:0]   w_trial;
    logic             w_co;
    logic             w_fits;
    logic             w_accept;
    logic             w_busy;

    // Shift the next dividend bit into the partial remainder.
    assign w_pshift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};

    addsub_step #(
        .N (WIDTH + 1)
    ) u_trial (
        .a    (w_pshift),
        .b    ({1'b0, r_d}),
        .mode (1'b1),
        .s    (w_trial),
        .co   (w_co)
    );

    // Subtract when the shifted remainder is >= divisor. P stays below D
    // between steps so its top bit is clear; a set top bit would only mean
    // the shifted value is certainly large enough.
    assign w_fits = w_co | r_p[WIDTH];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; START is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, one restoring step per RUN cycle, result publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= '0;
            r_d         <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div0      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_q    <= bus.dividend;
                r_d    <= bus.divisor;
                r_p    <= '0;
                r_cnt  <= CW'(WIDTH);
                r_div0 <= (bus.divisor == '0);
            end else if (r_state == S_RUN) begin
                if (w_fits) begin
                    r_p <= w_trial;
                    r_q <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_p <= w_pshift;
                    r_q <= {r_q[WIDTH-2:0], 1'b0};
                end
                r_cnt <= r_cnt - CW'(1);
            end else if (r_state == S_FINISH) begin
                r_quotient  <= r_q;
                r_remainder <= r_p[WIDTH-1:0];
                r_done      <= 1'b1;
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div0      = r_div0;

endmodule
`default_nettype wire

// File: doc/divider_seq.md
Name: divider_seq

Overview:
Sequential restoring unsigned divider, WIDTH-bit dividend / WIDTH-bit divisor. It computes one quotient bit per clock using a trial subtraction, built from the same two's-complement add/subtract step as our 8-bit adder/subtractor (B inverted, carry-in = 1). It sits beside the combinational adder in the arithmetic library, with a START/BUSY/DONE handshake toward the controlling logic.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (>= 2)

Ports:
CLK  input  1  rising-edge clock
RST  input  1  reset, asynchronous, active-high
START  input  1  request; sampled only when BUSY=0
DIVIDEND  input  WIDTH  unsigned dividend, sampled on accepted START
DIVISOR  input  WIDTH  unsigned divisor, sampled on accepted START
BUSY  output  1  high while a division is in progress
DONE  output  1  one-cycle pulse when results become valid
QUOTIENT  output  WIDTH  result quotient, held until next accepted START
REMAINDER  output  WIDTH  result remainder, held until next accepted START
DIV0  output  1  divisor was zero for the current result, held with results

Behaviour:
- One clock CLK; reset RST asynchronous, active-high. While RST=1: state=IDLE, BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV0=0, internal registers and counter=0.
- States: IDLE, RUN, FINISH.
- IDLE: on a CLK edge with START=1, latch DIVIDEND into the Q shift register and DIVISOR into the D register. Clear the WIDTH+1-bit partial remainder P to 0. Load the counter with WIDTH. Set DIV0 = (DIVISOR==0). Go to RUN, BUSY=1.
- RUN, each edge:
  - Form Pshift = {P[WIDTH-1:0], Q[WIDTH-1]}.
  - Compute T = Pshift + ~{1'b0,D} + 1 (WIDTH+1 bits, carry-out CO).
  - If CO=1 (no borrow): P=T and shift 1 into the Q LSB. Otherwise P=Pshift and shift 0 into the Q LSB.
  - Decrement the counter. When the counter reaches 0 after this step, go to FINISH.
- FINISH (one cycle): QUOTIENT=Q, REMAINDER=P[WIDTH-1:0], DONE=1, BUSY=0. Go to IDLE on the next edge, where DONE returns to 0.
- Latency: START accepted at edge 0 → WIDTH RUN edges → outputs update and DONE rises at edge WIDTH+1. BUSY is high from after edge 0 through edge WIDTH.
- START while BUSY=1 or in FINISH is ignored: no queuing, operands not resampled.
- START in the IDLE cycle immediately after FINISH is accepted normally. Back-to-back throughput is one result per WIDTH+2 cycles.
- Divide by zero: no special path. The algorithm naturally yields QUOTIENT = all ones and REMAINDER = DIVIDEND, with the full latency. DIV0=1 alongside.
- Outputs QUOTIENT/REMAINDER/DIV0 keep their previous result during a new RUN. They change only at FINISH, except that DIV0 updates at acceptance.
- RST asserted mid-operation aborts immediately to reset values. No DONE is produced for the aborted operation.
- Invariant at FINISH: DIVIDEND = QUOTIENT*DIVISOR + REMAINDER, and REMAINDER < DIVISOR when DIVISOR != 0.

Decomposition:
- Shared package `arith_pkg`:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_FINISH=2'd2;
  - counter-width function clog2(WIDTH+1).
- One sub-module `addsub_step`:
  - parameterised N-bit (N=WIDTH+1) ripple add/subtract with MODE input, B ^ {N{MODE}} and CI=MODE;
  - outputs S and CO;
  - instantiated with MODE=1 for the trial subtraction.

Test Plan:
- DIVIDEND=100, DIVISOR=7, START pulse → after 9 edges DONE=1 for one cycle, QUOTIENT=14, REMAINDER=2, DIV0=0, BUSY high exactly 8 cycles.
- 255/1 then back-to-back START in the IDLE cycle after DONE with 5/9 → first result Q=255 R=0, second result Q=0 R=5. Each DONE arrives 9 edges after its accepted START.
- 200/0 → Q=255, R=200, DIV0=1, latency unchanged.
- START held high with changing operands during RUN (100/7 accepted, then 50/3 presented mid-run) → only 100/7 result (14, 2), single DONE.
- RST asserted at RUN cycle 4 of 100/7 → all outputs 0 asynchronously, no DONE. A fresh 64/8 afterwards yields Q=8 R=0.
- Randomised sweep of all 65536 operand pairs against the reference model: quotient/remainder invariant holds, DIV0 correct.
